// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a byte-lane data memory.
// Checks alignment, drives a word-aligned memory access with lane-replicated
// store data and a byte mask, then extracts and extends the loaded data on
// the cycle the memory returns it.
module load_store_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_misalign,
  output logic          mem_en,
  output logic          mem_clr,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic [3:0]    mem_byte_ctrl,
  input  logic [DW-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic          err_q, err_d;
  logic          kill_q, kill_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;

  logic          accept;
  logic          misalign_in;
  logic [DW-1:0] fmt_wdata;
  logic [3:0]    fmt_mask;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [DW-1:0] load_data;

  // Request decode: alignment check, lane replication and byte-lane mask.
  always_comb begin
    req_ready   = (state_q == IDLE) || (state_q == RESP);
    accept      = req_valid && req_ready && !rst;
    misalign_in = (req_size == 2'b11) ||
                  ((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    fmt_wdata   = {4{req_wdata[7:0]}};
    fmt_mask    = 4'b0000;
    case (req_size)
      SZ_WORD: begin
        fmt_wdata = req_wdata;
        fmt_mask  = 4'b1111;
      end
      SZ_HALF: begin
        fmt_wdata = {2{req_wdata[15:0]}};
        fmt_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_BYTE: begin
        fmt_wdata = {4{req_wdata[7:0]}};
        fmt_mask  = 4'b0001 << req_addr[1:0];
      end
      default: begin
        fmt_wdata = {4{req_wdata[7:0]}};
        fmt_mask  = 4'b0000;
      end
    endcase
    // Loads never write a lane.
    if (!req_we) begin
      fmt_mask = 4'b0000;
    end
  end

  // Next-state logic and request capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    err_d   = err_q;
    kill_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = misalign_in ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
        // A flush here lets the access finish but hides its response.
        kill_d  = flush;
      end
      RESP: begin
        if (accept) begin
          state_d = misalign_in ? RESP : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      we_d    = req_we;
      size_d  = req_size;
      uns_d   = req_unsigned;
      off_d   = req_addr[1:0];
      err_d   = misalign_in;
      addr_d  = {req_addr[AW-1:2], 2'b00};
      wdata_d = fmt_wdata;
      mask_d  = fmt_mask;
    end
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      err_q   <= err_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

  // Memory port: only driven in ISSUE, and reset blocks a write in flight.
  always_comb begin
    mem_clr       = rst;
    mem_en        = (state_q == ISSUE) && !rst;
    mem_wr_en     = mem_en && we_q;
    mem_addr      = mem_en ? addr_q : '0;
    mem_wr_data   = mem_en ? wdata_q : '0;
    mem_byte_ctrl = mem_en ? mask_q : 4'b0000;
  end

  // Response: pick the addressed lane(s) from the returned word and extend.
  always_comb begin
    rd_byte   = mem_rd_data[{off_q, 3'b000} +: 8];
    rd_half   = off_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    load_data = mem_rd_data;
    case (size_q)
      SZ_HALF: load_data = uns_q ? {{(DW-16){1'b0}}, rd_half}
                                 : {{(DW-16){rd_half[15]}}, rd_half};
      SZ_BYTE: load_data = uns_q ? {{(DW-8){1'b0}}, rd_byte}
                                 : {{(DW-8){rd_byte[7]}}, rd_byte};
      default: load_data = mem_rd_data;
    endcase
    resp_valid    = (state_q == RESP) && !flush && !kill_q && !rst;
    resp_misalign = resp_valid && err_q;
    resp_rdata    = (resp_valid && !err_q && !we_q) ? load_data : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench. The driver pushes expected memory
// operations and responses computed from a byte-addressed golden memory; a
// monitor on the falling edge pops and compares whenever the DUT presents them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_clr, mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data;
  logic [3:0]  mem_byte_ctrl;
  logic [31:0] mem_rd_data = 32'h0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .mem_en(mem_en), .mem_clr(mem_clr),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_byte_ctrl(mem_byte_ctrl), .mem_rd_data(mem_rd_data)
  );

  // External data memory: registered read, byte-lane writes.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_clr) begin
      mem_rd_data <= 32'h0;
    end else if (mem_en) begin
      mem_rd_data <= mem[mem_addr[11:2]];
      for (int k = 0; k < 4; k++)
        if (mem_wr_en && mem_byte_ctrl[k])
          mem[mem_addr[11:2]][8*k +: 8] <= mem_wr_data[8*k +: 8];
    end
  end

  // Golden model: flat byte array.
  logic [7:0] gm [0:4095];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  bc;
    logic [31:0] wd;
  } mem_exp_t;
  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } resp_exp_t;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];
  int        mem_cycles[$];
  int        resp_cycles[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : (s == 2'b10) ? 1 : 0;
  endfunction

  // Monitor: compare whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (mem_en) begin
      mem_cycles.push_back(cyc);
      if (exp_mem.size() == 0) begin
        chk("mem_en_unexpected", 32'(mem_en), 32'h0);
      end else begin
        mem_exp_t e;
        e = exp_mem.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wr_en", 32'(mem_wr_en), 32'(e.we));
        chk("mem_byte_ctrl", 32'(mem_byte_ctrl), 32'(e.bc));
        if (e.we) chk("mem_wr_data", mem_wr_data, e.wd);
      end
    end else begin
      chk("mem_idle_zero", {mem_addr | mem_wr_data} | 32'(mem_byte_ctrl) | 32'(mem_wr_en), 32'h0);
    end
    if (resp_valid) begin
      resp_cycles.push_back(cyc);
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'h0);
      end else begin
        resp_exp_t r;
        r = exp_resp.pop_front();
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_misalign", 32'(resp_misalign), 32'(r.mis));
      end
    end else begin
      chk("resp_idle_zero", resp_rdata | 32'(resp_misalign), 32'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode: 0 plain, 1 flush on first cycle after accept, 2 flush on second
  // cycle after accept, 3 reset on first cycle after accept (aligned only).
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int mode);
    int n, waited;
    logic aligned, suppress;
    logic [31:0] val, msk;
    mem_exp_t me;
    resp_exp_t re;
    n = nbytes(size);
    aligned = (n != 0) && ((addr % n) == 0);
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    waited = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 20) begin
        chk("req_ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b0;
        return;
      end
    end
    // Expected results from the golden byte memory.
    if (aligned && mode != 3) begin
      me.addr = {addr[31:2], 2'b00};
      me.we   = we;
      msk     = ((32'h1 << n) - 1) << addr[1:0];
      me.bc   = we ? msk[3:0] : 4'b0000;
      for (int i = 0; i < 4; i++) me.wd[8*i +: 8] = wdata[8*(i % n) +: 8];
      exp_mem.push_back(me);
    end
    val = 32'h0;
    if (aligned && !we) begin
      for (int i = 0; i < n; i++) val = val | (32'(gm[addr + i]) << (8*i));
      if (n < 4 && !uns && val[8*n-1]) val = val | ~((32'h1 << (8*n)) - 1);
    end
    if (aligned && we && mode != 3)
      for (int i = 0; i < n; i++) gm[addr + i] = wdata[8*i +: 8];
    suppress = (mode == 3) || (mode == 1) || (aligned && mode == 2);
    if (!suppress) begin
      re.mis   = !aligned;
      re.rdata = (aligned && !we) ? val : 32'h0;
      exp_resp.push_back(re);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (mode == 1) flush = 1'b1;
    if (mode == 3) rst = 1'b1;
    if (mode == 2) begin
      @(posedge clk); #1;
      flush = 1'b1;
    end
    if (mode != 0) begin
      @(posedge clk); #1;
      flush = 1'b0;
      rst = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int k = 0; k < 4; k++) gm[4*i + k] = w[8*k +: 8];
    end
    rst = 1'b1; flush = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h0;
    // Reset held with a request pending.
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_clr", 32'(mem_clr), 32'h1);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mem_clr_released", 32'(mem_clr), 32'h0);
    send(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 0);
    idle(3);

    // Byte store/load on lane 3.
    send(1'b1, 2'b00, 1'b0, 32'h100, 32'h0, 0);
    send(1'b1, 2'b10, 1'b0, 32'h103, 32'h000000A5, 0);
    send(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 0);
    send(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 0);
    send(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0);
    idle(2);

    // Halfword store/load on upper half.
    send(1'b1, 2'b01, 1'b0, 32'h202, 32'h00008001, 0);
    send(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 0);
    send(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 0);
    idle(2);

    // Misaligned and illegal requests.
    send(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 0);
    send(1'b1, 2'b01, 1'b0, 32'h301, 32'h1234, 0);
    send(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 0);
    idle(2);

    // Back-to-back: second request accepted in the RESP cycle.
    mem_cycles.delete();
    resp_cycles.delete();
    send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0);
    send(1'b1, 2'b00, 1'b0, 32'h14, 32'hCAFEF00D, 0);
    idle(4);
    chk("b2b_resp_count", 32'(resp_cycles.size()), 32'd2);
    chk("b2b_mem_count", 32'(mem_cycles.size()), 32'd2);
    if (resp_cycles.size() == 2)
      chk("b2b_resp_spacing", 32'(resp_cycles[1] - resp_cycles[0]), 32'd2);
    if (mem_cycles.size() == 2)
      chk("b2b_mem_spacing", 32'(mem_cycles[1] - mem_cycles[0]), 32'd2);

    // Flush in ISSUE of a store: write lands, response hidden.
    send(1'b1, 2'b00, 1'b0, 32'h20, 32'h11223344, 1);
    send(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0);
    // Flush in RESP of a load.
    send(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 2);
    // Reset in ISSUE of a store: no write, back to IDLE.
    send(1'b1, 2'b00, 1'b0, 32'h24, 32'hDEADBEEF, 3);
    send(1'b0, 2'b00, 1'b0, 32'h24, 32'h0, 0);
    idle(2);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      logic we_r, uns_r;
      logic [1:0] sz_r;
      logic [31:0] a_r;
      int md, r, nb;
      we_r  = 1'($urandom_range(0, 1));
      uns_r = 1'($urandom_range(0, 1));
      sz_r  = 2'($urandom_range(0, 3));
      a_r   = 32'($urandom_range(0, 255));
      r     = $urandom_range(0, 9);
      md    = (r <= 6) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : 3;
      nb    = nbytes(sz_r);
      if (md == 3 && !(nb != 0 && (a_r % nb) == 0)) md = 0;
      send(we_r, sz_r, uns_r, a_r, $urandom, md);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(5);
    chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    chk("exp_resp_drained", 32'(exp_resp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
